// File: rtl/odo_sbox_bank.sv
// Double-buffered, runtime-reloadable S-box bank: LANES lookups per transfer from the
// active table while the shadow table streams in, is checked as a permutation and swapped in.
module odo_sbox_bank #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [WIDTH-1:0]         ld_data,
  input  logic                     ld_restart,
  input  logic                     swap_req,
  output logic                     swap_err,
  output logic                     table_live,
  output logic                     active_bank
);

  localparam int DEPTH = 1 << WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } ld_state_e;

  ld_state_e               state_q, state_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic [DEPTH-1:0]        seen_q, seen_d;
  logic                    dup_q, dup_d;
  logic                    swap_err_q, swap_err_d;
  logic                    bank_q, bank_d;
  logic                    live_q, live_d;
  logic                    out_valid_q;
  logic [LANES*WIDTH-1:0]  out_data_q;
  logic [LANES*WIDTH-1:0]  lookup;
  logic                    ld_beat;
  logic                    lk_accept;

  logic [WIDTH-1:0]        mem_q [2][DEPTH];

  assign ld_ready  = (state_q != FULL);
  assign ld_beat   = ld_valid & ld_ready & ~ld_restart;
  assign in_ready  = live_q & (~out_valid_q | out_ready);
  assign lk_accept = in_valid & in_ready;

  // NOTE: table storage has no reset; it is only read once table_live proves a full load was promoted.
  always_ff @(posedge clk) begin
    if (ld_beat) mem_q[~bank_q][cnt_q] <= ld_data;
  end

  // NOTE: every variable gets a default before any branch so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    dup_d      = dup_q;
    swap_err_d = 1'b0;
    bank_d     = bank_q;
    live_d     = live_q;
    if (ld_restart) begin
      state_d = IDLE;
      cnt_d   = '0;
      seen_d  = '0;
      dup_d   = 1'b0;
    end else begin
      if (ld_beat) begin
        cnt_d          = cnt_q + WIDTH'(1);
        seen_d[ld_data] = 1'b1;
        if (seen_q[ld_data]) dup_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (ld_beat)  state_d    = FILL;
          if (swap_req) swap_err_d = 1'b1;
        end
        FILL: begin
          if (ld_beat && (cnt_q == {WIDTH{1'b1}})) state_d = FULL;
          if (swap_req) swap_err_d = 1'b1;
        end
        FULL: begin
          if (swap_req) begin
            // A duplicate means the shadow is not a permutation: refuse and drop it.
            if (dup_q) begin
              swap_err_d = 1'b1;
            end else begin
              bank_d = ~bank_q;
              live_d = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
            seen_d  = '0;
            dup_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seen_q     <= '0;
      dup_q      <= 1'b0;
      swap_err_q <= 1'b0;
      bank_q     <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      dup_q      <= dup_d;
      swap_err_q <= swap_err_d;
      bank_q     <= bank_d;
      live_q     <= live_d;
    end
  end

  // Reads the bank active before any same-cycle swap, so the swap-cycle lookup sees the old table.
  always_comb begin
    lookup = '0;
    for (int i = 0; i < LANES; i++) begin
      lookup[i*WIDTH +: WIDTH] = mem_q[bank_q][in_data[i*WIDTH +: WIDTH]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (lk_accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lookup;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign swap_err    = swap_err_q;
  assign table_live  = live_q;
  assign active_bank = bank_q;

endmodule

// File: tb/tb_odo_sbox_bank.sv
// Self-checking bench for odo_sbox_bank: a transaction-level table model checked every cycle,
// plus directed scenarios with hand-computed lookup results.
module tb_odo_sbox_bank;

  localparam int W = 6;
  localparam int L = 4;
  localparam int D = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [L*W-1:0] out_data;
  logic           ld_valid = 1'b0;
  logic           ld_ready;
  logic [W-1:0]   ld_data = '0;
  logic           ld_restart = 1'b0;
  logic           swap_req = 1'b0;
  logic           swap_err;
  logic           table_live;
  logic           active_bank;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  odo_sbox_bank #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_restart(ld_restart), .swap_req(swap_req), .swap_err(swap_err),
    .table_live(table_live), .active_bank(active_bank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: two tables, a queue of shadow entries loaded so far, promoted if all distinct.
  logic [W-1:0]   tbl [2][D];
  logic [W-1:0]   shq [$];
  bit             m_live = 0, m_bank = 0, m_ov = 0, m_err = 0, m_full = 0;
  logic [L*W-1:0] m_od = '0;

  function automatic bit all_unique();
    bit s [D];
    for (int i = 0; i < D; i++) s[i] = 1'b0;
    foreach (shq[k]) begin
      if (s[shq[k]]) return 1'b0;
      s[shq[k]] = 1'b1;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live = 0; m_bank = 0; m_ov = 0; m_err = 0; m_full = 0; m_od = '0;
      shq.delete();
    end else begin
      bit old_full, old_bank;
      old_full = m_full;
      old_bank = m_bank;
      if (in_valid && m_live && (!m_ov || out_ready)) begin
        m_ov = 1;
        for (int i = 0; i < L; i++) m_od[i*W +: W] = tbl[old_bank][in_data[i*W +: W]];
      end else if (out_ready) begin
        m_ov = 0;
      end
      m_err = 0;
      if (ld_restart) begin
        shq.delete();
        m_full = 0;
      end else begin
        if (swap_req) begin
          if (!old_full) m_err = 1;
          else begin
            if (all_unique()) begin
              m_bank = !old_bank;
              m_live = 1;
            end else m_err = 1;
            shq.delete();
            m_full = 0;
          end
        end
        if (ld_valid && !old_full) begin
          tbl[!old_bank][shq.size()] = ld_data;
          shq.push_back(ld_data);
          if (shq.size() == D) m_full = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",    in_ready,    m_live && (!m_ov || out_ready));
      check("out_valid",   out_valid,   m_ov);
      check("out_data",    out_data,    m_od);
      check("ld_ready",    ld_ready,    !m_full);
      check("swap_err",    swap_err,    m_err);
      check("table_live",  table_live,  m_live);
      check("active_bank", active_bank, m_bank);
    end
  end

  logic [W-1:0] tab_id [D];
  logic [W-1:0] tab_b  [D];
  logic [W-1:0] tab_dup[D];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_range(input int sel, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ld_valid = 1'b1;
      ld_data  = (sel == 0) ? tab_id[i] : (sel == 1) ? tab_b[i] : tab_dup[i];
      tick();
      ld_valid = 1'b0;
      if ((i % 13) == 12) tick();
    end
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic lookup(input logic [L*W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < D; i++) begin
      tab_id[i]  = W'(i);
      tab_b[i]   = W'(i);
      tab_dup[i] = W'(i);
    end
    tab_b[0] = 6'h2c; tab_b[44] = 6'h00;
    tab_b[1] = 6'h38; tab_b[56] = 6'h01;
    tab_b[63] = 6'h07; tab_b[7] = 6'h3f;
    tab_dup[5] = 6'h04;

    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    #20 rst_n = 1'b1;
    tick();

    // No table yet: lookups must stall.
    in_valid = 1'b1;
    in_data  = {6'h01, 6'h02, 6'h03, 6'h04};
    #1 check("no_table_in_ready", in_ready, 0);
    tick(); tick();
    check("no_table_out_valid", out_valid, 0);
    in_valid = 1'b0;

    // Identity load and first promotion.
    load_range(0, 0, D);
    check("full_ld_ready", ld_ready, 0);
    do_swap();
    check("swap1_live", table_live, 1);
    check("swap1_bank", active_bank, 1);
    check("swap1_err",  swap_err, 0);
    lookup({6'h3f, 6'h2a, 6'h15, 6'h00});
    check("id_valid", out_valid, 1);
    check("id_data",  out_data, {6'h3f, 6'h2a, 6'h15, 6'h00});
    tick();
    check("id_drain", out_valid, 0);

    // Reload table B while lookups stream through the identity table.
    for (int i = 0; i < D; i++) begin
      ld_valid = 1'b1;
      ld_data  = tab_b[i];
      in_valid = 1'b1;
      in_data  = {W'(i), W'(63 - i), W'(i ^ 21), W'(i)};
      tick();
      check("stream_id", out_data, in_data);
    end
    ld_valid = 1'b0;
    in_data  = '0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap_cycle_old_bank", out_data, 24'h0);
    check("swap2_bank", active_bank, 0);
    tick();
    check("after_swap_new_bank", out_data, {4{6'h2c}});
    lookup({6'd63, 6'd1, 6'd0, 6'd44});
    check("tab_b_data", out_data, {6'h07, 6'h38, 6'h2c, 6'h00});

    // Duplicate entry: swap refused.
    load_range(2, 0, D);
    do_swap();
    check("dup_err",      swap_err, 1);
    check("dup_bank",     active_bank, 0);
    check("dup_ld_ready", ld_ready, 1);
    tick();
    check("dup_err_pulse", swap_err, 0);
    lookup({4{6'h00}});
    check("dup_unchanged", out_data, {4{6'h2c}});

    // Early swap after 10 beats, then complete the load.
    load_range(0, 0, 10);
    do_swap();
    check("early_err", swap_err, 1);
    load_range(0, 10, D);
    do_swap();
    check("late_ok_err",  swap_err, 0);
    check("late_ok_bank", active_bank, 1);
    lookup({6'd5, 6'd9, 6'd62, 6'd1});
    check("late_ok_data", out_data, {6'd5, 6'd9, 6'd62, 6'd1});

    // Last beat and swap_req together: refused, then FULL.
    load_range(1, 0, D - 1);
    ld_valid = 1'b1;
    ld_data  = tab_b[D-1];
    swap_req = 1'b1;
    tick();
    ld_valid = 1'b0;
    swap_req = 1'b0;
    check("last_beat_err",      swap_err, 1);
    check("last_beat_ld_ready", ld_ready, 0);
    do_swap();
    check("last_beat_bank", active_bank, 0);

    // Backpressure on the output register.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {6'd1, 6'd2, 6'd3, 6'd63};
    tick();
    in_data   = {6'd44, 6'd56, 6'd7, 6'd0};
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", out_data, {6'h38, 6'h02, 6'h03, 6'h07});
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_second", out_data, {6'h00, 6'h01, 6'h3f, 6'h2c});
    tick();
    check("bp_drain", out_valid, 0);

    // Restart at beat 30, then a full load.
    load_range(0, 0, 30);
    ld_restart = 1'b1;
    ld_valid   = 1'b1;
    ld_data    = 6'h11;
    tick();
    ld_restart = 1'b0;
    ld_valid   = 1'b0;
    check("restart_ld_ready", ld_ready, 1);
    load_range(0, 0, D);
    do_swap();
    check("restart_swap_err",  swap_err, 0);
    check("restart_swap_bank", active_bank, 1);

    // Asynchronous reset in the middle of traffic.
    in_valid = 1'b1;
    in_data  = {6'd3, 6'd4, 6'd5, 6'd6};
    ld_valid = 1'b1;
    ld_data  = 6'h03;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",    in_ready, 0);
    check("rst_out_valid",   out_valid, 0);
    check("rst_out_data",    out_data, 0);
    check("rst_ld_ready",    ld_ready, 1);
    check("rst_swap_err",    swap_err, 0);
    check("rst_table_live",  table_live, 0);
    check("rst_active_bank", active_bank, 0);
    #10 rst_n = 1'b1;
    ld_valid = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 0);
    tick();
    check("post_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odo_sbox_bank.md
# odo_sbox_bank

Parametrised, runtime-reloadable S-box lookup bank for the Odo hash core. It serves LANES parallel WIDTH-bit substitutions per cycle from an active table, while a shadow table is streamed in for the next epoch and swapped in atomically. Loaded tables are checked to be permutations before a swap. The bank sits between the round-input register and the mixing stage, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 6, S-box input/output width; table depth is 2^WIDTH
- LANES, 4, independent lookups per transfer
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  lookup request valid
- in_ready  out  1  bank can accept a lookup
- in_data  in  LANES*WIDTH  lane i index at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  LANES*WIDTH  lane i = table[in lane i]
- ld_valid  in  1  table entry beat valid
- ld_ready  out  1  shadow accepts a beat
- ld_data  in  WIDTH  next table entry; address is implicit, ascending from 0
- ld_restart  in  1  discard the partial or complete shadow and restart at entry 0
- swap_req  in  1  single-cycle request to promote the shadow to active
- swap_err  out  1  single-cycle pulse: swap refused
- table_live  out  1  an active table exists
- active_bank  out  1  index of the bank serving lookups

## Operation
- Two banks of 2^WIDTH x WIDTH storage. Storage is not reset.
- Load FSM states:
  - IDLE: cnt=0, ld_ready=1. An accepted beat (ld_valid & ld_ready) writes shadow[cnt], increments cnt, and moves to FILL.
  - FILL: ld_ready=1. Each beat writes shadow[cnt], then cnt++. The beat at cnt=2^WIDTH-1 moves to FULL.
  - FULL: ld_ready=0. On swap_req, the swap is checked (see below) and the FSM returns to IDLE.
- Permutation check: a 2^WIDTH-bit seen bitmap is cleared on entry to IDLE. Each beat sets seen[ld_data]. If that bit was already set, a sticky dup flag is raised.
- Swap, evaluated only in FULL:
  - If dup=0: active_bank toggles, table_live is set, and the FSM returns to IDLE.
  - If dup=1: swap_err pulses, the shadow is discarded, active_bank is unchanged, and the FSM returns to IDLE.
- swap_req in IDLE or FILL: swap_err pulses for one cycle; no other effect.
- ld_restart in any state: the FSM goes to IDLE (cnt=0, bitmap and dup cleared) and any same-cycle ld beat is dropped. ld_restart takes priority over swap_req.
- Lookup path: single output register with stall.
  - in_ready = table_live & (!out_valid | out_ready).
  - On accept, each lane's out_data is registered from the bank active in that cycle. out_valid rises on the next edge.
  - out_data holds while out_valid & !out_ready.
- Swap vs. lookup in the same cycle: a lookup accepted in the swap cycle uses the old bank. Lookups from the next cycle onward use the new bank. Results already held in the output register are unaffected.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, ld_ready=1 (IDLE), swap_err=0, table_live=0, active_bank=0, cnt=0, dup=0.
- Lookup latency is 1 cycle, accept edge to out_valid. Full throughput of one transfer per cycle when out_ready=1.
- Loading a full table takes 2^WIDTH accepted beats; gaps are allowed.
- The swap takes effect at the edge on which swap_req is sampled in FULL. table_live and active_bank update on that edge, and ld_ready returns to 1 in the next cycle.
- swap_err is registered and asserted for exactly one cycle, the cycle after the offending swap_req.
- The last beat and swap_req in the same cycle: the FSM is still in FILL, so swap_err pulses and the FSM then enters FULL.
- Reset asserted mid-operation: all registers return to reset values immediately. The previous active table is treated as lost (table_live=0) and must be reloaded.

## Test plan
- Post-reset: in_valid=1 with no table -> in_ready=0 and out_valid stays 0. Load 64 beats of the identity table (WIDTH=6, LANES=4), then swap -> table_live=1, active_bank=1. Lookup 0x00,0x15,0x2a,0x3f -> the same four values one cycle later.
- Reload while live: load a table with entry 0=0x2c, 1=0x38, 63=0x07 (rest a valid permutation) while lookups stream. Lookups before the swap return identity values; lookup index 0 in the cycle after the swap returns 0x2c; active_bank=0.
- Duplicate entry: load identity with entry 5 = 0x04, then swap -> swap_err pulses once, active_bank and lookup results are unchanged, ld_ready=1 again.
- Early swap: swap_req after 10 beats -> swap_err pulse. Continue with 54 beats, then swap -> succeeds.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_data is held, in_ready=0, no lookup is lost or duplicated. Release -> results come out in order.
- Abort and reset: ld_restart at beat 30 -> cnt restarts at 0 and a full 64-beat load then succeeds. rst_n low mid-stream -> all outputs match the reset values on the same cycle.
